// File: rtl/lbuf_pkg.sv
// Shared constants and types for the line buffer bank.
// Holds default geometry and the pixel type used by the design and its bench.
package lbuf_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_LINE_LEN = 256;
    localparam int DEF_N_LINES  = 2;

    typedef logic [DEF_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/line_mem.sv
// Single-port line memory: synchronous write, combinational read of the
// addressed word, so a same-cycle access returns the old contents.
module line_mem #(
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 256,
    parameter int ADDR_W   = $clog2(LINE_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [LINE_LEN];

    // NOTE: storage has no reset; stale contents are masked by the fill state.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer_bank.sv
// Cascaded line delays producing a registered vertical column of taps
// (slice k = pixel from k lines ago) with column index and fill status.
module line_buffer_bank
    import lbuf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LINE_LEN = DEF_LINE_LEN,
    parameter int N_LINES  = DEF_N_LINES,
    parameter int COL_W    = $clog2(LINE_LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          flush,
    output logic                          out_valid,
    output logic [(N_LINES+1)*DATA_W-1:0] out_taps,
    output logic [COL_W-1:0]              out_col,
    output logic                          out_eol,
    output logic                          primed
);

    localparam int                CNT_W    = $clog2(N_LINES + 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(N_LINES);

    logic [COL_W-1:0]              ptr;
    logic [CNT_W-1:0]              line_cnt;
    logic [CNT_W-1:0]              line_cnt_nxt;
    logic                          accept;
    logic                          at_eol;
    logic [DATA_W-1:0]             rd_data [N_LINES];
    logic [(N_LINES+1)*DATA_W-1:0] taps_nxt;

    assign accept = in_valid & ~flush;
    assign at_eol = (ptr == LAST_COL);

    // Each memory shifts the previous memory's old word down one line.
    assign taps_nxt[DATA_W-1:0] = in_data;

    for (genvar k = 0; k < N_LINES; k++) begin : g_line
        logic [DATA_W-1:0] wdata;

        if (k == 0) begin : g_head
            assign wdata = in_data;
        end else begin : g_chain
            assign wdata = rd_data[k-1];
        end

        line_mem #(
            .DATA_W   (DATA_W),
            .LINE_LEN (LINE_LEN),
            .ADDR_W   (COL_W)
        ) u_mem (
            .clk   (clk),
            .we    (accept & ~rst),
            .addr  (ptr),
            .wdata (wdata),
            .rdata (rd_data[k])
        );

        assign taps_nxt[(k+1)*DATA_W +: DATA_W] = rd_data[k];
    end

    // NOTE: default assignment first so no latch is inferred.
    always_comb begin
        line_cnt_nxt = line_cnt;
        if (at_eol && (line_cnt != FULL_CNT)) begin
            line_cnt_nxt = line_cnt + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            line_cnt <= '0;
            primed   <= 1'b0;
        end else if (flush) begin
            ptr      <= '0;
            line_cnt <= '0;
            primed   <= 1'b0;
        end else if (in_valid) begin
            ptr      <= at_eol ? '0 : ptr + COL_W'(1);
            line_cnt <= line_cnt_nxt;
            primed   <= (line_cnt_nxt == FULL_CNT);
        end
    end

    // Taps, column and eol hold whenever no pixel is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_taps  <= '0;
            out_col   <= '0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= accept & primed;
            if (accept) begin
                out_taps <= taps_nxt;
                out_col  <= ptr;
                out_eol  <= at_eol;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_bank.sv
// Self-checking bench for line_buffer_bank with LINE_LEN=4, N_LINES=2, DATA_W=8.
module tb_line_buffer_bank;
    import lbuf_pkg::*;

    localparam int DW  = 8;
    localparam int LL  = 4;
    localparam int NL  = 2;
    localparam int CW  = 2;
    localparam int TW  = (NL + 1) * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic [TW-1:0] out_taps;
    logic [CW-1:0] out_col;
    logic          out_eol;
    logic          primed;

    int n_checks = 0;
    int n_fail   = 0;

    line_buffer_bank #(
        .DATA_W   (DW),
        .LINE_LEN (LL),
        .N_LINES  (NL),
        .COL_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_taps  (out_taps),
        .out_col   (out_col),
        .out_eol   (out_eol),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            rst;
        bit            v;
        logic [DW-1:0] d;
        bit            e_valid;
        bit            e_primed;
        logic [CW-1:0] e_col;
        bit            e_eol;
        bit            chk_taps;
        logic [TW-1:0] e_taps;
    } vec_t;

    vec_t vecs [13];

    // Reference model state: pixels accepted since the last reset/flush.
    pixel_t        hist [$];
    int            n_acc;
    bit            e_valid, e_primed, e_eol, taps_known, col_known;
    logic [TW-1:0] e_taps;
    logic [CW-1:0] e_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input bit f, input logic [DW-1:0] d);
        rst      = r;
        in_valid = v;
        flush    = f;
        in_data  = d;
        if (r) begin
            n_acc = 0; hist.delete();
            e_valid = 0; e_primed = 0; e_taps = '0; e_col = '0; e_eol = 0;
            taps_known = 1; col_known = 1;
        end else if (f) begin
            n_acc = 0; hist.delete();
            e_valid = 0; e_primed = 0;
            taps_known = 0; col_known = 0;
        end else if (v) begin
            hist.push_back(d);
            n_acc++;
            e_valid   = (n_acc > 2 * LL);
            e_col     = CW'((n_acc - 1) % LL);
            e_eol     = ((n_acc - 1) % LL) == LL - 1;
            col_known = 1;
            if (e_valid) begin
                e_taps     = {hist[n_acc-9], hist[n_acc-5], d};
                taps_known = 1;
            end else begin
                taps_known = 0;
            end
            e_primed = (n_acc >= 2 * LL);
        end else begin
            e_valid = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("primed", 32'(primed), 32'(e_primed));
        if (taps_known) check("out_taps", 32'(out_taps), 32'(e_taps));
        if (col_known) begin
            check("out_col", 32'(out_col), 32'(e_col));
            check("out_eol", 32'(out_eol), 32'(e_eol));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0;

        // Continuous stream 1..12 after reset, explicit expectations.
        vecs[0] = '{rst: 1, v: 0, d: 0, e_valid: 0, e_primed: 0, e_col: 0,
                    e_eol: 0, chk_taps: 1, e_taps: '0};
        for (int p = 1; p <= 12; p++) begin
            vecs[p] = '{rst: 0, v: 1, d: DW'(p), e_valid: (p >= 9), e_primed: (p >= 8),
                        e_col: CW'((p - 1) % 4), e_eol: (p % 4 == 0), chk_taps: (p >= 9),
                        e_taps: {DW'(p - 8), DW'(p - 4), DW'(p)}};
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].v; flush = 1'b0; in_data = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            check($sformatf("tbl%0d_primed", i), 32'(primed), 32'(vecs[i].e_primed));
            check($sformatf("tbl%0d_col", i), 32'(out_col), 32'(vecs[i].e_col));
            check($sformatf("tbl%0d_eol", i), 32'(out_eol), 32'(vecs[i].e_eol));
            if (vecs[i].chk_taps)
                check($sformatf("tbl%0d_taps", i), 32'(out_taps), 32'(vecs[i].e_taps));
        end

        // Same stream with an idle cycle after every pixel.
        cycle(1, 0, 0, 0);
        for (int p = 1; p <= 12; p++) begin
            cycle(0, 1, 0, DW'(p));
            cycle(0, 0, 0, 8'hEE);
        end

        // Flush collides with a pixel: pixel dropped, refill from scratch.
        cycle(1, 0, 0, 0);
        for (int p = 1; p <= 10; p++) cycle(0, 1, 0, DW'(p));
        cycle(0, 1, 1, 8'd99);
        for (int p = 1; p <= 10; p++) cycle(0, 1, 0, DW'(p + 40));

        // Reset mid-line discards the partial line.
        cycle(1, 0, 0, 0);
        for (int p = 1; p <= 6; p++) cycle(0, 1, 0, DW'(p));
        cycle(1, 1, 0, 8'h55);
        for (int p = 1; p <= 10; p++) cycle(0, 1, 0, DW'(p));

        // Long random run with sporadic idle cycles.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3) == 0) cycle(0, 0, 0, DW'($urandom));
            cycle(0, 1, 0, DW'($urandom));
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_bank.md
LINE_BUFFER_BANK -- requirements
Module: line_buffer_bank

Interface
REQ-001 Parameter DATA_W, default 8: pixel width in bits.
REQ-002 Parameter LINE_LEN, default 256: pixels per image line; SHALL be 2 or greater.
REQ-003 Parameter N_LINES, default 2: number of line delays; SHALL be 1 or greater.
REQ-004 Parameter COL_W, default $clog2(LINE_LEN): column index width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input pixel present this cycle.
REQ-008 in_data  in  DATA_W  input pixel, raster order.
REQ-009 flush  in  1  restart frame: clears pointers and fill state.
REQ-010 out_valid  out  1  out_taps and out_col valid this cycle.
REQ-011 out_taps  out  (N_LINES+1)*DATA_W  vertical column; slice k = pixel from k lines ago; slice 0 at LSBs.
REQ-012 out_col  out  COL_W  column index of the output column.
REQ-013 out_eol  out  1  output column is the last in its line.
REQ-014 primed  out  1  all N_LINES line memories hold valid data.

Function
REQ-015 The block SHALL hold N_LINES line memories of LINE_LEN x DATA_W, sharing one write/read pointer ptr (0..LINE_LEN-1).
REQ-016 On an accepted pixel (in_valid=1, flush=0), each memory SHALL read before write at ptr: mem[0][ptr] gets in_data; mem[k][ptr] gets the old mem[k-1][ptr] for k>=1.
REQ-017 Slice 0 of out_taps SHALL be in_data, and slice k SHALL be the old mem[k-1][ptr]; all outputs registered, latency exactly 1 cycle.
REQ-018 ptr SHALL increment per accepted pixel and wrap from LINE_LEN-1 to 0, with no dead cycle. This is a generic wrap, not a hard-coded constant.
REQ-019 A line counter SHALL increment on each wrap and saturate at N_LINES; primed SHALL equal (line counter == N_LINES), registered.
REQ-020 out_valid SHALL be 1 exactly one cycle after an accepted pixel while primed was already 1 at acceptance; otherwise 0.
REQ-021 out_col SHALL be the ptr value of the accepted pixel, and out_eol SHALL be 1 when that ptr was LINE_LEN-1.
REQ-022 in_valid=0 SHALL freeze ptr, line counter and memories, and out_valid SHALL be 0 the next cycle; out_taps, out_col and out_eol SHALL hold.
REQ-023 flush=1 SHALL set ptr=0, line counter=0 and primed=0 next cycle, and out_valid=0; memory contents are kept but treated as invalid.
REQ-024 If flush and in_valid are both 1 in the same cycle, flush SHALL win and the pixel SHALL be dropped.
REQ-025 There is no backpressure: every in_valid=1 pixel (absent flush) SHALL be accepted.

Reset
REQ-026 With rst=1 at a clock edge: ptr=0, line counter=0, primed=0, out_valid=0, out_taps=0, out_col=0, out_eol=0.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 rst SHALL have priority over flush and in_valid, and reset mid-line SHALL discard the partial line.

Structure
REQ-029 Package lbuf_pkg SHALL hold the default DATA_W, LINE_LEN and N_LINES constants and a pixel_t typedef (logic [DATA_W-1:0]).
REQ-030 One sub-module, line_mem, SHALL be used: a single-port LINE_LEN x DATA_W RAM with synchronous write and read-before-write.
REQ-031 The top SHALL instantiate N_LINES line_mem copies in a generate loop, plus ptr/line-counter control.

Verification (LINE_LEN=4, N_LINES=2, DATA_W=8)
REQ-032 Reset then stream 1..12 continuously -> primed rises after pixel 8. Pixels 9..12 give out_valid=1 with taps {p, p-4, p-8}; e.g. pixel 9 gives {9,5,1}, out_col 0..3, out_eol only with pixel 12.
REQ-033 Same stream with in_valid=0 every other cycle -> identical tap sequence; out_valid never high on the cycle after an idle input cycle.
REQ-034 Stream 1..10, then flush with in_valid=1 and data 99 -> 99 dropped; primed=0, and the next 8 pixels produce no out_valid.
REQ-035 Assert rst mid-line after pixel 6 -> all outputs 0 next cycle; restart stream 1..8 -> primed rises after pixel 8 exactly.
REQ-036 Long run of 1000 pixels with a scoreboard model -> every out_valid column matches {p, p-4, p-8}; ptr wraps with no lost pixel.
